// File: rtl/fadd_arbiter_if.sv
// Requester-side bus of fadd_arbiter: request handshake and operands in,
// per-requester response handshake and data out.
//   req_valid/req_ready/req_sub : one bit per requester
//   req_op1/req_op2/resp_data   : 32 bits per requester, requester i at [32i+31:32i]
//   resp_valid/resp_ready       : one bit per requester
// master = requester side, slave = arbiter side.
interface fadd_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    req_sub;
    logic [32*N_REQ-1:0] req_op1;
    logic [32*N_REQ-1:0] req_op2;
    logic [N_REQ-1:0]    resp_valid;
    logic [N_REQ-1:0]    resp_ready;
    logic [32*N_REQ-1:0] resp_data;

    modport master (
        output req_valid, req_sub, req_op1, req_op2, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_sub, req_op1, req_op2, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin sharing of one fixed-latency fadd pipeline among N_REQ requesters.
// A tag pipeline follows each operation through the fadd so the result lands in
// the issuing requester's response FIFO; per-requester credits equal to the FIFO
// depth guarantee a result always has room, since the fadd cannot be stalled.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : requester request/response bus (slave modport)
//   fadd_op1/op2 : registered operands to the fadd (op2 sign flipped for subtract)
//   fadd_reset   : active-low reset to the fadd, combinational ~reset
//   fadd_result  : fadd output, valid FADD_LATENCY+1 cycles after the grant
module fadd_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned FADD_LATENCY = 3,
    parameter int unsigned RESP_DEPTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    fadd_arbiter_if.slave bus,
    output logic [31:0]   fadd_op1,
    output logic [31:0]   fadd_op2,
    output logic          fadd_reset,
    input  logic [31:0]   fadd_result
);
    localparam int unsigned TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [TW-1:0]                 rr_ptr;
    logic [N_REQ-1:0]              credit_nz;
    logic [N_REQ-1:0]              eligible;
    logic [N_REQ-1:0]              ready_c;
    logic [N_REQ-1:0]              grant;
    logic                          grant_any;
    logic [TW-1:0]                 grant_idx;
    logic [31:0]                   sel_op1;
    logic [31:0]                   sel_op2;
    logic [FADD_LATENCY:0]         tag_v;
    logic [FADD_LATENCY:0][TW-1:0] tag_id;
    logic                          tail_v;
    logic [TW-1:0]                 tail_id;
    logic [N_REQ-1:0]              resp_valid_c;
    logic [32*N_REQ-1:0]           resp_data_c;

    assign fadd_reset = ~reset;

    // No grants while in reset so nothing is issued into a clearing pipeline.
    assign eligible = bus.req_valid & credit_nz & {N_REQ{~reset}};

    // Round-robin pick: search starts just after the last granted requester.
    always_comb begin
        int unsigned cand;
        ready_c   = '0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = 32'(rr_ptr) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (ready_c == '0 && eligible[TW'(cand)]) begin
                ready_c[TW'(cand)] = 1'b1;
                grant_idx          = TW'(cand);
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign grant         = bus.req_valid & ready_c;
    assign grant_any     = |grant;

    // Operand mux; subtract is an add with op2's sign bit inverted.
    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_op1 = bus.req_op1[32*i +: 32];
                sel_op2 = bus.req_op2[32*i +: 32] ^ {bus.req_sub[i], 31'd0};
            end
        end
    end

    // Operand register, arbitration pointer and tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= TW'(N_REQ - 1);
            fadd_op1 <= '0;
            fadd_op2 <= '0;
            tag_v    <= '0;
            tag_id   <= '0;
        end else begin
            if (grant_any) rr_ptr <= grant_idx;
            fadd_op1 <= sel_op1;
            fadd_op2 <= sel_op2;
            tag_v    <= {tag_v[FADD_LATENCY-1:0], grant_any};
            tag_id   <= {tag_id[FADD_LATENCY-1:0], grant_idx};
        end
    end

    // Tail lines up with fadd_result of the same operation.
    assign tail_v  = tag_v[FADD_LATENCY];
    assign tail_id = tag_id[FADD_LATENCY];

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        logic [31:0]   mem [RESP_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] count;
        logic [CW-1:0] credit;
        logic          wr;
        logic          pop;

        assign wr           = tail_v && (tail_id == TW'(g));
        assign pop          = (count != '0) && bus.resp_ready[g];
        assign credit_nz[g] = (credit != '0);
        assign resp_valid_c[g]          = (count != '0);
        assign resp_data_c[32*g +: 32]  = mem[rd_ptr];

        // Response storage; credits make a write into a full FIFO impossible.
        always_ff @(posedge clk) begin
            if (!reset && wr) mem[wr_ptr] <= fadd_result;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                credit <= CW'(RESP_DEPTH);
            end else begin
                if (wr)  wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                if (pop) rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                case ({wr, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
                // A credit leaves on grant and returns when its result is consumed.
                case ({grant[g], pop})
                    2'b10:   credit <= credit - CW'(1);
                    2'b01:   credit <= credit + CW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = resp_data_c;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: integer-valued floats through a 3-stage fadd model,
// scoreboard of per-requester expected results with arrival times, directed
// scenarios followed by a randomized run.
module tb_fadd_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LAT   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fadd_op1;
    logic [31:0] fadd_op2;
    logic        fadd_reset;
    logic [31:0] fadd_result;
    logic [31:0] fs1, fs2, fs3;

    fadd_arbiter_if #(.N_REQ(N)) bus ();

    fadd_arbiter #(.N_REQ(N), .FADD_LATENCY(3), .RESP_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fadd_op1    (fadd_op1),
        .fadd_op2    (fadd_op2),
        .fadd_reset  (fadd_reset),
        .fadd_result (fadd_result)
    );

    always #5 clk = ~clk;

    // Integer <-> single-precision helpers (exact for |v| < 2^24).
    function automatic logic [31:0] i2f(input int v);
        int unsigned mag;
        int          e;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? int'(-v) : int'(v);
        for (e = 23; e > 0 && !mag[e]; e--) ;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'(mag << (23 - e));
        return r;
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int          e;
        int unsigned m;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = 32'({1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -int'(m) : int'(m);
    endfunction

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b, input logic s);
        return i2f(f2i(a) + f2i(s ? {~b[31], b[30:0]} : b));
    endfunction

    function automatic logic [31:0] rand_f();
        return i2f(int'($urandom_range(0, 100000)) - 50000);
    endfunction

    // External fadd: three registered stages, active-low reset.
    always @(posedge clk) begin
        if (!fadd_reset) begin
            fs1 <= '0; fs2 <= '0; fs3 <= '0;
        end else begin
            fs1 <= i2f(f2i(fadd_op1) + f2i(fadd_op2));
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end
    assign fadd_result = fs3;

    typedef struct {
        int unsigned due;
        logic [31:0] val;
    } exp_t;

    exp_t        mq [N][$];
    int unsigned last_g;
    logic [31:0] exp_op1, exp_op2;
    int unsigned cyc;
    bit          armed;
    logic [N-1:0] obs_ready;
    int          checks, failures;
    int          g2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.req_valid[i]          = 1'b1;
        bus.req_op1[32*i +: 32]   = a;
        bus.req_op2[32*i +: 32]   = b;
        bus.req_sub[i]            = s;
    endtask

    task automatic rand_ops();
        for (int unsigned i = 0; i < N; i++) begin
            bus.req_op1[32*i +: 32] = rand_f();
            bus.req_op2[32*i +: 32] = rand_f();
            bus.req_sub[i]          = 1'($urandom);
        end
    endtask

    // One clock cycle: check outputs against the model, advance the model, clock.
    task automatic tick();
        logic [N-1:0] pred;
        logic [N-1:0] exp_rv;
        logic         r;
        #1;
        r    = reset;
        pred = '0;
        if (!r) begin
            for (int unsigned off = 1; off <= N; off++) begin
                int unsigned c;
                c = (last_g + off) % N;
                if (pred == '0 && bus.req_valid[c] && mq[c].size() < DEPTH) pred[c] = 1'b1;
            end
        end
        exp_rv = '0;
        for (int unsigned i = 0; i < N; i++)
            if (mq[i].size() > 0 && mq[i][0].due <= cyc) exp_rv[i] = 1'b1;
        obs_ready = bus.req_ready;
        if (armed) begin
            chk("req_ready", 32'(bus.req_ready), 32'(pred));
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            for (int unsigned i = 0; i < N; i++)
                if (exp_rv[i]) chk($sformatf("resp_data%0d", i), bus.resp_data[32*i +: 32], mq[i][0].val);
            chk("fadd_op1", fadd_op1, exp_op1);
            chk("fadd_op2", fadd_op2, exp_op2);
            for (int unsigned i = 0; i < N; i++)
                if (bus.req_ready[i] && bus.req_valid[i])
                    chk($sformatf("fifo_overflow%0d", i), 32'(mq[i].size() < DEPTH), 32'd1);
        end
        if (r) begin
            for (int unsigned i = 0; i < N; i++) mq[i].delete();
            last_g  = N - 1;
            exp_op1 = '0;
            exp_op2 = '0;
        end else begin
            exp_op1 = '0;
            exp_op2 = '0;
            for (int unsigned i = 0; i < N; i++)
                if (exp_rv[i] && bus.resp_ready[i]) void'(mq[i].pop_front());
            for (int unsigned i = 0; i < N; i++) begin
                if (pred[i]) begin
                    exp_t e;
                    e.due   = cyc + LAT;
                    e.val   = model_sum(bus.req_op1[32*i +: 32], bus.req_op2[32*i +: 32], bus.req_sub[i]);
                    mq[i].push_back(e);
                    last_g  = i;
                    exp_op1 = bus.req_op1[32*i +: 32];
                    exp_op2 = bus.req_op2[32*i +: 32] ^ {bus.req_sub[i], 31'd0};
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (r) armed = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; armed = 1'b0; last_g = N - 1;
        exp_op1 = '0; exp_op2 = '0; g2 = 0;
        reset = 1'b1;
        bus.req_valid = '1; bus.req_op1 = '0; bus.req_op2 = '0; bus.req_sub = '0;
        bus.resp_ready = '1;
        @(posedge clk); #1;

        // Reset state, with all requests asserted.
        tick(); tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_fadd_reset", 32'(fadd_reset), 32'd0);
        reset = 1'b0;
        bus.req_valid = '0;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_fadd_op1", fadd_op1, 32'd0);
        chk("rst_fadd_op2", fadd_op2, 32'd0);

        // Single add: 1.0 + 2.0 from requester 0.
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        tick();
        bus.req_valid = '0;
        chk("add_op1", fadd_op1, 32'h3F800000);
        repeat (4) tick();
        chk("add_resp_valid", 32'(bus.resp_valid), 32'h1);
        chk("add_resp_data", bus.resp_data[31:0], 32'h40400000);
        tick();

        // Subtract: 3.0 - 1.0 from requester 1.
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        tick();
        bus.req_valid = '0;
        chk("sub_op2", fadd_op2, 32'hBF800000);
        repeat (4) tick();
        chk("sub_resp_valid", 32'(bus.resp_valid), 32'h2);
        chk("sub_resp_data", bus.resp_data[63:32], 32'h40000000);
        tick();

        // Round robin from a fresh reset: 0,1,2,3,... with no gaps.
        reset = 1'b1; tick(); reset = 1'b0;
        bus.req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            rand_ops();
            tick();
            chk("rr_grant", 32'(obs_ready), 32'(1) << (k % 4));
        end
        bus.req_valid = '0;
        repeat (8) tick();

        // Backpressure on requester 2: exactly DEPTH grants, then resume.
        bus.resp_ready = 4'b1011;
        bus.req_valid  = '1;
        g2 = 0;
        for (int k = 0; k < 20; k++) begin
            rand_ops();
            tick();
            if (obs_ready[2]) g2++;
        end
        chk("bp_grants2", 32'(g2), 32'(DEPTH));
        bus.resp_ready = '1;
        g2 = 0;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            tick();
            if (obs_ready[2]) g2++;
        end
        chk("bp_regrant2", 32'(g2 > 0), 32'd1);
        bus.req_valid = '0;
        repeat (8) tick();

        // Grant and pop in the same cycle with one credit left.
        bus.resp_ready = 4'b1110;
        rand_ops();
        set_req(0, rand_f(), rand_f(), 1'b0);
        tick();
        chk("sim_g1", 32'(obs_ready), 32'h1);
        tick();
        chk("sim_g2", 32'(obs_ready), 32'h1);
        bus.req_valid = '0;
        repeat (4) tick();
        bus.resp_ready = '1;
        tick();
        bus.req_valid = 4'b0001;
        tick();
        chk("sim_grant_pop", 32'(obs_ready), 32'h1);
        tick();
        chk("sim_next_grant", 32'(obs_ready), 32'h1);
        tick();
        chk("sim_blocked", 32'(obs_ready), 32'h0);
        bus.req_valid = '0;
        repeat (8) tick();

        // Reset two cycles after three grants discards everything in flight.
        for (int unsigned i = 0; i < 3; i++) begin
            bus.req_valid = '0;
            set_req(i, rand_f(), rand_f(), 1'b0);
            tick();
        end
        bus.req_valid = '0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mf_fadd_op1", fadd_op1, 32'd0);
        chk("mf_fadd_op2", fadd_op2, 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk("mf_no_resp", 32'(bus.resp_valid), 32'd0);
            tick();
        end
        bus.req_valid = '1;
        rand_ops();
        tick();
        chk("mf_first_grant", 32'(obs_ready), 32'h1);
        bus.req_valid = 4'b0001;
        tick();
        chk("mf_credit2", 32'(obs_ready), 32'h1);
        tick();
        chk("mf_credit_out", 32'(obs_ready), 32'h0);
        bus.req_valid = '0;
        repeat (8) tick();

        // Randomized traffic with random consumer stalls.
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            bus.req_valid  = 4'($urandom);
            bus.resp_ready = 4'($urandom) | 4'($urandom);
            tick();
        end
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
- Shares one fadd pipeline (3 registered stages, no valid/enable) among N_REQ requesters using round-robin arbitration.
- Registers the granted operands into fadd, and for subtract requests flips the sign of op2.
- Carries a request tag alongside the fadd pipeline so each result returns to the requester that issued it.
- Each requester has its own small response FIFO, protected by per-requester credits, so a stalled consumer never drops results. The fadd has no stall input.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FADD_LATENCY, 3, fadd cycles from operand sample to result register.
- RESP_DEPTH, 2, per-requester response FIFO depth, which is also that requester's credit count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; at most one bit high.
- req_op1  in  32*N_REQ  operand 1 of requester i at bits [32i+31:32i].
- req_op2  in  32*N_REQ  operand 2 of requester i, same packing.
- req_sub  in  N_REQ  1 = compute op1 - op2.
- fadd_op1  out  32  to fadd op1, registered.
- fadd_op2  out  32  to fadd op2, registered.
- fadd_reset  out  1  to fadd reset; fadd reset is active-low, so this is ~reset, combinational.
- fadd_result  in  32  from fadd result.
- resp_valid  out  N_REQ  per-requester response valid.
- resp_ready  in  N_REQ  per-requester response accept.
- resp_data  out  32*N_REQ  per-requester result, same packing.

Behaviour:
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i]!=0.
- Arbitration (combinational):
  - Priority starts at rr_ptr+1 and wraps around modulo N_REQ.
  - req_ready = one-hot of the first eligible requester, or all zero if none.
  - A grant is the handshake req_valid[i] & req_ready[i] in cycle T.
  - On a grant, rr_ptr <= i; otherwise rr_ptr holds.
- Operand register, updated at the end of cycle T:
  - Grant: fadd_op1 <= req_op1[i]; fadd_op2 <= req_op2[i] with bit 31 XORed by req_sub[i].
  - No grant: fadd_op1 and fadd_op2 are both loaded with 0.
- Tag pipeline:
  - {valid, tag[$clog2(N_REQ)-1:0]} shift register of FADD_LATENCY+1 stages, aligned with the operand register and the fadd stages.
  - Stage 0 is loaded at the end of T; a bubble loads valid=0.
  - fadd_result for a grant in cycle T is valid during cycle T+1+FADD_LATENCY (T+4 at default). The tag-pipeline tail is examined in that same cycle.
- Response FIFOs:
  - A valid tail with tag k writes fadd_result into FIFO k at the end of cycle T+1+FADD_LATENCY.
  - resp_valid[k] is high during T+2+FADD_LATENCY (T+5). Total latency is 5 cycles, with no bypass.
  - resp_valid[k] = FIFO k not empty; resp_data[k] = FIFO k head.
  - The head pops on resp_valid & resp_ready.
  - FIFO order equals grant order for that requester.
- Credits:
  - credit[i] starts at RESP_DEPTH; a grant decrements it and a pop increments it.
  - Grant and pop in the same cycle leave credit unchanged.
  - credit[i] = 0 blocks requester i; other requesters are unaffected.
  - A FIFO write into a full FIFO cannot occur by construction; a bench assertion checks this.
- Throughput:
  - One grant per cycle is sustained whenever any requester is eligible.
  - A single requester alone is limited to RESP_DEPTH grants per 5 + drain cycles.
- Reset (synchronous, sampled at the clock edge):
  - After reset, rr_ptr=N_REQ-1, so requester 0 has first priority.
  - All credits return to RESP_DEPTH.
  - All FIFOs are emptied and resp_valid=0.
  - All tag valids are cleared, discarding in-flight operations.
  - fadd_op1 and fadd_op2 are 0.
  - req_ready is all zero while reset=1.
  - fadd_reset is 0 while reset=1, so the fadd clears in the same edge.
  - Reset mid-operation produces no spurious response afterwards.
- Data handling: NaN, Inf and denormal operands are passed through unchanged; results are whatever fadd produces.

Test Plan:
- Single add: req 0 sends 0x3F800000 + 0x40000000, sub=0 at T -> resp_valid[0]=1 at T+5 with resp_data 0x40400000. No other resp_valid bit rises.
- Subtract: req 1 sends 0x40400000, 0x3F800000, sub=1 -> fadd_op2=0xBF800000 at T+1; resp_data[1]=0x40000000 at T+5.
- Round robin: all 4 requesters valid continuously with resp_ready=all 1 -> grants 0,1,2,3,0,1,... one per cycle, with no gaps. Each response carries that requester's own operands' sum, in order.
- Backpressure: resp_ready[2]=0 and all requesters valid -> requester 2 gets exactly 2 grants, then req_ready[2] stays 0. Others keep rotating among 0,1,3. Raising resp_ready[2] pops 2 results in order and req 2 is granted again.
- Simultaneous grant and pop: req 0 with credit 1 gets a grant in the same cycle its FIFO pops -> credit stays 1 and the next grant is allowed.
- Reset mid-flight: assert reset for 1 cycle 2 cycles after 3 grants -> no resp_valid for 10 cycles. Credits read RESP_DEPTH, the first grant goes to requester 0, and the fadd outputs 0.
